// File: rtl/trisc_core.sv
// -----------------------------------------------------------------------------
// trisc_core
// Parametrised accumulator CPU core with a multi-cycle control FSM
// (FETCH / DECODE / MEM / PAUSE / HALT). It talks to an external
// program/data memory over a request/ready handshake that tolerates wait
// states.
//
// Parameters
//   W    data / address / operand width
//   OPW  opcode width (the ISA is defined for 4)
//
// Ports
//   sysclock    in   core clock, rising edge
//   sysreset    in   asynchronous active-low reset
//   step_mode   in   1 = pause after every retired instruction
//   step        in   one-cycle pulse that releases a pause
//   mem_rd      out  read request (instruction fetch or operand read)
//   mem_wr      out  write request (STA)
//   mem_addr    out  transfer address
//   mem_wdata   out  write data, {0, acc}
//   mem_rdata   in   read data, valid while mem_ready=1
//   mem_ready   in   completes the current request this cycle
//   pc, ir, acc out  architectural trace state
//   zf, cf      out  zero / carry flags
//   halted      out  core is in HALT
//   instr_done  out  one-cycle pulse after an instruction retires
// -----------------------------------------------------------------------------
module trisc_core #(
    parameter int W   = 4,
    parameter int OPW = 4
) (
    input  logic             sysclock,
    input  logic             sysreset,
    input  logic             step_mode,
    input  logic             step,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [W-1:0]     mem_addr,
    output logic [OPW+W-1:0] mem_wdata,
    input  logic [OPW+W-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [W-1:0]     pc,
    output logic [OPW+W-1:0] ir,
    output logic [W-1:0]     acc,
    output logic             zf,
    output logic             cf,
    output logic             halted,
    output logic             instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_PAUSE  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_CLR = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t             state_q;
    logic [W-1:0]       pc_q;
    logic [OPW+W-1:0]   ir_q;
    logic [W-1:0]       acc_q;
    logic               zf_q;
    logic               cf_q;
    logic               halted_q;
    logic               instr_done_q;

    logic [3:0]         op_s;
    logic [W-1:0]       opnd_s;
    logic [W-1:0]       mdata_s;
    logic [W:0]         wide_s;
    logic [W-1:0]       acc_d;
    logic               cf_d;
    logic               zf_d;
    logic               acc_wr_s;
    logic               is_memop_s;
    state_t             retire_state_s;

    assign op_s    = ir_q[W +: 4];
    assign opnd_s  = ir_q[W-1:0];
    assign mdata_s = mem_rdata[W-1:0];

    // ALU: result, carry and accumulator write-enable for the current opcode.
    // Memory ops take their operand from mem_rdata; they only commit in MEM,
    // register ops only commit in DECODE, so one shared ALU serves both.
    always_comb begin
        acc_d    = acc_q;
        cf_d     = cf_q;
        acc_wr_s = 1'b0;
        wide_s   = {(W+1){1'b0}};
        case (op_s)
            OP_LDA: begin
                acc_d    = mdata_s;
                acc_wr_s = 1'b1;
            end
            OP_ADD: begin
                wide_s   = {1'b0, acc_q} + {1'b0, mdata_s};
                acc_d    = wide_s[W-1:0];
                cf_d     = wide_s[W];
                acc_wr_s = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (acc < M).
                wide_s   = {1'b0, acc_q} - {1'b0, mdata_s};
                acc_d    = wide_s[W-1:0];
                cf_d     = wide_s[W];
                acc_wr_s = 1'b1;
            end
            OP_AND: begin
                acc_d    = acc_q & mdata_s;
                acc_wr_s = 1'b1;
            end
            OP_OR: begin
                acc_d    = acc_q | mdata_s;
                acc_wr_s = 1'b1;
            end
            OP_LDI: begin
                acc_d    = opnd_s;
                acc_wr_s = 1'b1;
            end
            OP_INC: begin
                wide_s   = {1'b0, acc_q} + {{W{1'b0}}, 1'b1};
                acc_d    = wide_s[W-1:0];
                cf_d     = wide_s[W];
                acc_wr_s = 1'b1;
            end
            OP_CLR: begin
                acc_d    = {W{1'b0}};
                cf_d     = 1'b0;
                acc_wr_s = 1'b1;
            end
            default: begin
                acc_d    = acc_q;
                cf_d     = cf_q;
                acc_wr_s = 1'b0;
            end
        endcase
        zf_d = (acc_d == {W{1'b0}});
    end

    // Decode helpers: memory-op class and where a retiring instruction goes.
    always_comb begin
        is_memop_s = (op_s == OP_LDA) || (op_s == OP_STA) || (op_s == OP_ADD) ||
                     (op_s == OP_SUB) || (op_s == OP_AND) || (op_s == OP_OR);
        if (step_mode) begin
            retire_state_s = S_PAUSE;
        end else begin
            retire_state_s = S_FETCH;
        end
    end

    // Control FSM together with the architectural registers it updates.
    always_ff @(posedge sysclock or negedge sysreset) begin
        if (!sysreset) begin
            state_q      <= S_FETCH;
            pc_q         <= {W{1'b0}};
            ir_q         <= {(OPW+W){1'b0}};
            acc_q        <= {W{1'b0}};
            zf_q         <= 1'b0;
            cf_q         <= 1'b0;
            halted_q     <= 1'b0;
            instr_done_q <= 1'b0;
        end else begin
            instr_done_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_q + {{(W-1){1'b0}}, 1'b1};
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_memop_s) begin
                        state_q <= S_MEM;
                    end else if (op_s == OP_HLT) begin
                        instr_done_q <= 1'b1;
                        halted_q     <= 1'b1;
                        state_q      <= S_HALT;
                    end else begin
                        if ((op_s == OP_JMP) ||
                            ((op_s == OP_JZ) && zf_q) ||
                            ((op_s == OP_JC) && cf_q)) begin
                            pc_q <= opnd_s;
                        end
                        if (acc_wr_s) begin
                            acc_q <= acc_d;
                            zf_q  <= zf_d;
                            cf_q  <= cf_d;
                        end
                        instr_done_q <= 1'b1;
                        state_q      <= retire_state_s;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (acc_wr_s) begin
                            acc_q <= acc_d;
                            zf_q  <= zf_d;
                            cf_q  <= cf_d;
                        end
                        instr_done_q <= 1'b1;
                        state_q      <= retire_state_s;
                    end
                end
                S_PAUSE: begin
                    // A step pulse or leaving step mode resumes execution.
                    if (step || !step_mode) begin
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes are decoded from registered state only, so address/data stay
    // stable across wait states; they are gated by reset so an in-flight
    // transfer is dropped the moment reset is asserted.
    assign mem_rd    = sysreset && ((state_q == S_FETCH) ||
                                    ((state_q == S_MEM) && (op_s != OP_STA)));
    assign mem_wr    = sysreset && (state_q == S_MEM) && (op_s == OP_STA);
    assign mem_addr  = (state_q == S_MEM) ? opnd_s : pc_q;
    assign mem_wdata = {{OPW{1'b0}}, acc_q};

    assign pc         = pc_q;
    assign ir         = ir_q;
    assign acc        = acc_q;
    assign zf         = zf_q;
    assign cf         = cf_q;
    assign halted     = halted_q;
    assign instr_done = instr_done_q;

endmodule

// File: tb/tb_trisc_core.sv
// -----------------------------------------------------------------------------
// tb_trisc_core
// Directed self-checking bench for trisc_core. One W=4 instance runs the
// arithmetic, branch, wait-state and single-step programs; one W=8 instance
// covers reset during an operand read and pc wrap-around. Memories are
// read-only arrays loaded by the bench; writes are checked on the bus.
// -----------------------------------------------------------------------------
module tb_trisc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst8, step_mode, step, ready4, ready8;

    logic        rd4, wr4, zf4, cf4, halted4, done4;
    logic [3:0]  addr4, pc4, acc4;
    logic [7:0]  wdata4, rdata4, ir4;
    logic [7:0]  mem4 [0:15];

    logic        rd8, wr8, zf8, cf8, halted8, done8;
    logic [7:0]  addr8, pc8, acc8;
    logic [11:0] wdata8, rdata8, ir8;
    logic [11:0] mem8 [0:255];

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt4   = 0;

    assign rdata4 = mem4[addr4];
    assign rdata8 = mem8[addr8];

    trisc_core #(.W(4), .OPW(4)) u4 (
        .sysclock(clk), .sysreset(rst4), .step_mode(step_mode), .step(step),
        .mem_rd(rd4), .mem_wr(wr4), .mem_addr(addr4), .mem_wdata(wdata4),
        .mem_rdata(rdata4), .mem_ready(ready4),
        .pc(pc4), .ir(ir4), .acc(acc4), .zf(zf4), .cf(cf4),
        .halted(halted4), .instr_done(done4)
    );

    trisc_core #(.W(8), .OPW(4)) u8 (
        .sysclock(clk), .sysreset(rst8), .step_mode(step_mode), .step(step),
        .mem_rd(rd8), .mem_wr(wr8), .mem_addr(addr8), .mem_wdata(wdata8),
        .mem_rdata(rdata8), .mem_ready(ready8),
        .pc(pc8), .ir(ir8), .acc(acc8), .zf(zf8), .cf(cf8),
        .halted(halted8), .instr_done(done8)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done4 === 1'b1) done_cnt4++;
    endtask

    task automatic clear_mem4();
        for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
    endtask

    initial begin
        rst4 = 1'b0; rst8 = 1'b0; step_mode = 1'b0; step = 1'b0;
        ready4 = 1'b1; ready8 = 1'b1;
        clear_mem4();
        for (int i = 0; i < 256; i++) mem8[i] = 12'h000;

        // ---------------- program A: LDI 5; INC; HLT ----------------
        mem4[0] = 8'h75; mem4[1] = 8'h80; mem4[2] = 8'hF0;
        tick(); tick();
        check("rst_pc",     16'(pc4), 16'h0);
        check("rst_ir",     16'(ir4), 16'h0);
        check("rst_acc",    16'(acc4), 16'h0);
        check("rst_zf",     16'(zf4), 16'h0);
        check("rst_cf",     16'(cf4), 16'h0);
        check("rst_halted", 16'(halted4), 16'h0);
        check("rst_done",   16'(done4), 16'h0);
        check("rst_rd",     16'(rd4), 16'h0);
        check("rst_wr",     16'(wr4), 16'h0);
        check("rst8_rd",    16'(rd8), 16'h0);
        rst4 = 1'b1;
        #1;
        check("first_fetch_rd",   16'(rd4), 16'h1);
        check("first_fetch_addr", 16'(addr4), 16'h0);
        tick();
        check("A_c1_ir", 16'(ir4), 16'h75);
        check("A_c1_pc", 16'(pc4), 16'h1);
        tick();
        check("A_c2_acc",  16'(acc4), 16'h5);
        check("A_c2_done", 16'(done4), 16'h1);
        tick(); tick();
        check("A_c4_acc", 16'(acc4), 16'h6);
        check("A_c4_zf",  16'(zf4), 16'h0);
        check("A_c4_cf",  16'(cf4), 16'h0);
        tick(); tick();
        check("A_c6_halted", 16'(halted4), 16'h1);
        check("A_c6_pc",     16'(pc4), 16'h3);
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick();
        check("A_halt_sticky",  16'(halted4), 16'h1);
        check("A_halt_rd",      16'(rd4), 16'h0);
        check("A_halt_wr",      16'(wr4), 16'h0);
        check("A_halt_pc",      16'(pc4), 16'h3);
        check("A_done_pulses",  16'(done_cnt4), 16'd3);

        // ---------------- program B: LDI 1; ADD 8; JC 0 ----------------
        rst4 = 1'b0;
        #1;
        check("B_rst_halted", 16'(halted4), 16'h0);
        clear_mem4();
        mem4[0] = 8'h71; mem4[1] = 8'h38; mem4[2] = 8'hC0; mem4[8] = 8'h0F;
        tick(); rst4 = 1'b1;
        tick(); tick();
        check("B_ldi_acc", 16'(acc4), 16'h1);
        tick(); tick();
        check("B_mem_rd",   16'(rd4), 16'h1);
        check("B_mem_addr", 16'(addr4), 16'h8);
        tick();
        check("B_add_acc", 16'(acc4), 16'h0);
        check("B_add_cf",  16'(cf4), 16'h1);
        check("B_add_zf",  16'(zf4), 16'h1);
        tick(); tick();
        check("B_jc_ir", 16'(ir4), 16'hC0);
        check("B_jc_pc", 16'(pc4), 16'h0);

        // ------- program C: LDI 2; SUB 9; JZ 0; STA 10; NOP ... -------
        rst4 = 1'b0;
        clear_mem4();
        mem4[0] = 8'h72; mem4[1] = 8'h49; mem4[2] = 8'hB0; mem4[3] = 8'h2A;
        mem4[9] = 8'h03;
        tick(); rst4 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("C_sub_acc", 16'(acc4), 16'hF);
        check("C_sub_cf",  16'(cf4), 16'h1);
        check("C_sub_zf",  16'(zf4), 16'h0);
        tick(); tick();
        check("C_jz_ir", 16'(ir4), 16'hB0);
        check("C_jz_pc", 16'(pc4), 16'h3);
        tick(); tick();
        ready4 = 1'b0;
        check("C_sta_wr",    16'(wr4), 16'h1);
        check("C_sta_rd",    16'(rd4), 16'h0);
        check("C_sta_addr",  16'(addr4), 16'hA);
        check("C_sta_wdata", 16'(wdata4), 16'h0F);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("C_wait_wr",    16'(wr4), 16'h1);
            check("C_wait_addr",  16'(addr4), 16'hA);
            check("C_wait_wdata", 16'(wdata4), 16'h0F);
            check("C_wait_done",  16'(done4), 16'h0);
        end
        ready4 = 1'b1;
        tick();
        check("C_sta_done",    16'(done4), 16'h1);
        check("C_sta_wr_drop", 16'(wr4), 16'h0);
        check("C_next_rd",     16'(rd4), 16'h1);
        check("C_next_addr",   16'(addr4), 16'h4);

        // ---------------- single-step on the NOP tail ----------------
        step_mode = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        check("S_dec_ir", 16'(ir4), 16'h00);
        tick();
        check("S_retire_done", 16'(done4), 16'h1);
        check("S_retire_pc",   16'(pc4), 16'h5);
        check("S_pause_rd",    16'(rd4), 16'h0);
        check("S_pause_wr",    16'(wr4), 16'h0);
        tick();
        check("S_hold_rd",   16'(rd4), 16'h0);
        check("S_hold_done", 16'(done4), 16'h0);
        tick();
        check("S_hold2_rd", 16'(rd4), 16'h0);
        check("S_hold2_pc", 16'(pc4), 16'h5);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("S_step_rd",   16'(rd4), 16'h1);
        check("S_step_addr", 16'(addr4), 16'h5);
        tick(); tick();
        check("S_step_done", 16'(done4), 16'h1);
        check("S_step_pc",   16'(pc4), 16'h6);
        check("S_step_rd0",  16'(rd4), 16'h0);
        step_mode = 1'b0;
        tick();
        check("S_resume_rd",   16'(rd4), 16'h1);
        check("S_resume_addr", 16'(addr4), 16'h6);

        // ------------- W=8: reset during an operand read -------------
        mem8[0] = 12'h75A; mem8[1] = 12'h180; mem8[8'h80] = 12'h0C3;
        rst8 = 1'b1;
        tick(); tick();
        check("W8_ldi_acc", 16'(acc8), 16'h5A);
        tick();
        check("W8_lda_ir", 16'(ir8), 16'h180);
        ready8 = 1'b0;
        tick();
        check("W8_mem_rd",   16'(rd8), 16'h1);
        check("W8_mem_addr", 16'(addr8), 16'h80);
        check("W8_mem_wr",   16'(wr8), 16'h0);
        tick();
        check("W8_wait_rd", 16'(rd8), 16'h1);
        rst8 = 1'b0;
        #1;
        check("W8_rst_rd",     16'(rd8), 16'h0);
        check("W8_rst_wr",     16'(wr8), 16'h0);
        check("W8_rst_pc",     16'(pc8), 16'h0);
        check("W8_rst_ir",     16'(ir8), 16'h0);
        check("W8_rst_acc",    16'(acc8), 16'h0);
        check("W8_rst_zf",     16'(zf8), 16'h0);
        check("W8_rst_cf",     16'(cf8), 16'h0);
        check("W8_rst_halted", 16'(halted8), 16'h0);
        check("W8_rst_done",   16'(done8), 16'h0);
        check("W8_rst_wdata",  16'(wdata8), 16'h0);

        // ---------------- W=8: JMP 0xFF; NOP -> pc wraps ----------------
        mem8[0] = 12'hAFF; mem8[255] = 12'h000;
        ready8 = 1'b1;
        tick();
        rst8 = 1'b1;
        #1;
        check("W8_restart_rd",   16'(rd8), 16'h1);
        check("W8_restart_addr", 16'(addr8), 16'h00);
        tick();
        check("W8_jmp_ir", 16'(ir8), 16'hAFF);
        check("W8_jmp_pc", 16'(pc8), 16'h01);
        tick();
        check("W8_jmp_taken", 16'(pc8), 16'hFF);
        tick();
        check("W8_wrap_pc", 16'(pc8), 16'h00);
        check("W8_wrap_ir", 16'(ir8), 16'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
